// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants and FSM encoding for the frequency-control path
package dds_pkg;

    localparam logic [3:0]  DIGIT_BLANK  = 4'hF;
    localparam logic [15:0] BLANK_FIELD  = 16'hFFFF;
    localparam int          FREQ_CTL_W   = 12;
    localparam int          FREQ_CTL_MAX = 4095;
    localparam int          ACC_W        = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_mac.sv
// rtl/bcd_digit_mac.sv - combinational acc*10+digit step with digit classification
module bcd_digit_mac
    import dds_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_next,
    output logic             is_num,
    output logic             is_blank
);

    logic [ACC_W-1:0] digit_val;

    // Blank and illegal nibbles contribute zero; the caller decides whether they are errors.
    always_comb begin
        is_blank  = (digit == DIGIT_BLANK);
        is_num    = (digit <= 4'd9);
        digit_val = is_num ? {{(ACC_W-4){1'b0}}, digit} : '0;
        acc_next  = (acc << 3) + (acc << 1) + digit_val;
    end

endmodule

// File: rtl/bcd_freq_ctl.sv
// rtl/bcd_freq_ctl.sv - sequential BCD display word to binary freq_ctl decoder (BCD_FREQ_CTL_CLAMP_EN: saturate overflow to 4095)
module bcd_freq_ctl
    import dds_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = FREQ_CTL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] freq_ctl,
    output logic             err
);

    localparam int IDX_W = $clog2(DIGITS);

    state_t                  state, state_next;
    logic [4*DIGITS-1:0]     word;
    logic [IDX_W-1:0]        idx;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_next;
    logic                    fmt_err;
    logic                    seen_num;
    logic                    is_num;
    logic                    is_blank;
    logic                    fmt_err_next;
    logic                    overflow;
    logic [3:0]              digit;

    assign digit = word[{idx, 2'b00} +: 4];

    bcd_digit_mac u_mac (
        .acc      (acc),
        .digit    (digit),
        .acc_next (acc_next),
        .is_num   (is_num),
        .is_blank (is_blank)
    );

    // A blank is only legal while no numeric digit has been seen yet.
    assign fmt_err_next = fmt_err | (is_blank & seen_num) | (!is_num & !is_blank);
    assign overflow     = (acc_next > ACC_W'(FREQ_CTL_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_CONV;
            end
            ST_CONV: begin
                if (idx == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word     <= '0;
            idx      <= '0;
            acc      <= '0;
            fmt_err  <= 1'b0;
            seen_num <= 1'b0;
            freq_ctl <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        word     <= in_data[4*DIGITS-1:0];
                        idx      <= IDX_W'(DIGITS-1);
                        acc      <= '0;
                        fmt_err  <= (in_data[31:16] != BLANK_FIELD);
                        seen_num <= 1'b0;
                    end
                end
                ST_CONV: begin
                    acc      <= acc_next;
                    idx      <= idx - 1'b1;
                    seen_num <= seen_num | is_num;
                    fmt_err  <= fmt_err_next;
                    if (idx == '0) begin
`ifdef BCD_FREQ_CTL_CLAMP_EN
                        if (fmt_err_next) begin
                            freq_ctl <= '0;
                            err      <= 1'b1;
                        end else if (overflow) begin
                            freq_ctl <= OUT_W'(FREQ_CTL_MAX);
                            err      <= 1'b0;
                        end else begin
                            freq_ctl <= acc_next[OUT_W-1:0];
                            err      <= 1'b0;
                        end
`else
                        if (fmt_err_next || overflow) begin
                            freq_ctl <= '0;
                            err      <= 1'b1;
                        end else begin
                            freq_ctl <= acc_next[OUT_W-1:0];
                            err      <= 1'b0;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_freq_ctl.sv
// tb/tb_bcd_freq_ctl.sv - randomized and directed self-checking bench for bcd_freq_ctl
module tb_bcd_freq_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] freq_ctl;
    logic        err;

    int n_chk = 0;
    int n_pass = 0;

    bcd_freq_ctl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .freq_ctl  (freq_ctl),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    endtask

    // Reference decoding straight from the digit rules: {err, freq_ctl}.
    function automatic logic [12:0] decode(input logic [31:0] w);
        int         v = 0;
        bit         bad = (w[31:16] != 16'hFFFF);
        bit         seen = 0;
        logic [3:0] d;
        for (int i = 3; i >= 0; i--) begin
            d = w[i*4 +: 4];
            if (d == 4'hF) begin
                if (seen) bad = 1;
            end else if (d > 4'd9) begin
                bad = 1;
            end else begin
                seen = 1;
                v = v * 10 + int'(d);
            end
        end
        if (bad) return {1'b1, 12'd0};
`ifdef BCD_FREQ_CTL_CLAMP_EN
        if (v > 4095) return {1'b0, 12'd4095};
`else
        if (v > 4095) return {1'b1, 12'd0};
`endif
        return {1'b0, 12'(v)};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w = 32'hFFFF0000;
        int nb = int'($urandom % 5);
        int r  = int'($urandom % 10);
        int k  = int'($urandom % 4);
        for (int i = 0; i < 4; i++) w[i*4 +: 4] = (i >= 4 - nb) ? 4'hF : 4'($urandom % 10);
        if (r == 0) w[k*4 +: 4] = 4'hA + 4'($urandom % 5);
        if (r == 1) w[31:16] = 16'($urandom);
        if (r == 2) w[k*4 +: 4] = 4'hF;
        return w;
    endfunction

    // Transaction-level model: an accepted word is busy for 4 cycles, then
    // its result is presented until taken; the result registers hold afterwards.
    int          ph = 0;
    logic [31:0] mword = 32'h0;
    logic [11:0] exp_f = 12'd0;
    logic        exp_e = 1'b0;
    logic        acc_pulse = 1'b0;
    int          cyc = 0;
    int          acc_times[$];
    bit          mon_en = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph        <= 0;
            exp_f     <= 12'd0;
            exp_e     <= 1'b0;
            acc_pulse <= 1'b0;
        end else begin
            cyc       <= cyc + 1;
            acc_pulse <= (ph == 0) && in_valid;
            if (ph == 0 && in_valid) begin
                mword <= in_data;
                ph    <= 1;
                acc_times.push_back(cyc);
            end else if (ph >= 1 && ph <= 3) begin
                ph <= ph + 1;
            end else if (ph == 4) begin
                ph             <= 5;
                {exp_e, exp_f} <= decode(mword);
            end else if (ph == 5 && out_ready) begin
                ph <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", 32'(in_ready), 32'(ph == 0));
            chk("out_valid", 32'(out_valid), 32'(ph == 5));
            chk("freq_ctl", 32'(freq_ctl), 32'(exp_f));
            chk("err", 32'(err), 32'(exp_e));
        end
    end

    task automatic do_word(input logic [31:0] w, input logic [11:0] ef, input logic ee,
                           input int stall, input string nm);
        int n;
        out_ready = 1'b0;
        in_data   = w;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        chk({nm, "_in_ready_to"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk({nm, "_latency"}, 32'(n), 32'd4);
        chk({nm, "_freq"}, 32'(freq_ctl), 32'(ef));
        chk({nm, "_err"}, 32'(err), 32'(ee));
        chk({nm, "_model"}, 32'(decode(w)), 32'({ee, ef}));
        repeat (stall) begin @(posedge clk); #1; end
        chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_hold_freq"}, 32'(freq_ctl), 32'(ef));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_ret_ready"}, 32'(in_ready), 32'd1);
        chk({nm, "_after_freq"}, 32'(freq_ctl), 32'(ef));
    endtask

    initial begin
        int n;
        int start;
        int prev;
        int cnt;

        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_freq", 32'(freq_ctl), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_word(32'hFFFF1234, 12'd1234, 1'b0, 3, "w1234");
        do_word(32'hFFFFFF07, 12'd7,    1'b0, 0, "w7");
        do_word(32'hFFFFFFFF, 12'd0,    1'b0, 1, "wblank");
        do_word(32'hFFFF1F23, 12'd0,    1'b1, 0, "wembed");
        do_word(32'hFFFF12A4, 12'd0,    1'b1, 2, "whex");
        do_word(32'h00001234, 12'd0,    1'b1, 0, "wfield");
        do_word(32'hFFFF4095, 12'd4095, 1'b0, 0, "w4095");
`ifdef BCD_FREQ_CTL_CLAMP_EN
        do_word(32'hFFFF4096, 12'd4095, 1'b0, 1, "w4096");
        do_word(32'hFFFF9999, 12'd4095, 1'b0, 0, "w9999");
`else
        do_word(32'hFFFF4096, 12'd0,    1'b1, 1, "w4096");
        do_word(32'hFFFF9999, 12'd0,    1'b1, 0, "w9999");
`endif

        // Reset in the middle of a conversion.
        in_data  = 32'hFFFF0777;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("mid_rst_no_result", 32'(n), 32'd0);
        chk("mid_rst_freq", 32'(freq_ctl), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        do_word(32'hFFFF0042, 12'd42, 1'b0, 0, "w42");

        // Back-to-back: fresh data every cycle, only IDLE-cycle words are consumed.
        start     = cyc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (62) begin
            in_data = rand_word();
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cnt  = 0;
        prev = -1;
        foreach (acc_times[i]) begin
            if (acc_times[i] >= start) begin
                if (prev >= 0) chk("b2b_interval", 32'(acc_times[i] - prev), 32'd6);
                prev = acc_times[i];
                cnt++;
            end
        end
        chk("b2b_count", 32'(cnt >= 10), 32'd1);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure.
        for (int c = 0; c < 600; c++) begin
            if (acc_pulse || !in_valid) begin
                in_valid = (($urandom % 3) != 0);
                in_data  = rand_word();
            end
            out_ready = (($urandom % 4) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("end_idle", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
